// File: rtl/mxn_elastic_pipeline.sv
// C independent W-bit lanes, each a D-stage elastic delay line.
// A stage accepts a new word when it is empty or its content moves on, so
// bubbles collapse under back-pressure and the lane streams at full rate when
// the consumer is always ready. Occupancy is a registered count of valid stages.

module mxn_elastic_lane #(
    parameter int W  = 3,
    parameter int D  = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] occupancy
);

    logic [D-1:0]        r_v;
    logic [D-1:0][W-1:0] r_d;
    logic [CW-1:0]       r_occ;

    logic [D-1:0]        w_ld;
    logic [D-1:0]        w_vsrc;
    logic [D-1:0][W-1:0] w_dsrc;
    logic [D-1:0]        w_v_nxt;
    logic                w_in_acc;

    function automatic logic [CW-1:0] f_popcnt(input logic [D-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < D; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    // Load-enable chain: ready ripples from the output back to stage 0 in one cycle.
    always_comb begin : ld_chain
        logic a;
        a    = out_ready;
        w_ld = '0;
        for (int s = D - 1; s >= 0; s--) begin
            a       = ~r_v[s] | a;
            w_ld[s] = a;
        end
    end

    assign in_ready = w_ld[0] & ~flush;
    assign w_in_acc = in_valid & in_ready;

    // Source of each stage: the stage below, or the lane input for stage 0.
    always_comb begin
        w_vsrc    = '0;
        w_dsrc    = '0;
        w_vsrc[0] = w_in_acc;
        w_dsrc[0] = in_data;
        for (int s = 1; s < D; s++) begin
            w_vsrc[s] = r_v[s-1];
            w_dsrc[s] = r_d[s-1];
        end
    end

    // Next valid vector; flush empties the lane but leaves data untouched.
    always_comb begin
        w_v_nxt = '0;
        for (int s = 0; s < D; s++)
            w_v_nxt[s] = flush ? 1'b0 : (w_ld[s] ? w_vsrc[s] : r_v[s]);
    end

    // Stage registers; data only captures when a valid word lands in the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_d   <= '0;
            r_occ <= '0;
        end else begin
            r_v   <= w_v_nxt;
            r_occ <= f_popcnt(w_v_nxt);
            for (int s = 0; s < D; s++)
                if (!flush && w_ld[s] && w_vsrc[s]) r_d[s] <= w_dsrc[s];
        end
    end

    assign out_valid = r_v[D-1];
    assign out_data  = r_d[D-1];
    assign occupancy = r_occ;

endmodule

module mxn_elastic_pipeline #(
    parameter int W = 3,
    parameter int D = 4,
    parameter int C = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [C-1:0]               flush,
    input  logic [C-1:0]               in_valid,
    output logic [C-1:0]               in_ready,
    input  logic [C*W-1:0]             in_data,
    output logic [C-1:0]               out_valid,
    input  logic [C-1:0]               out_ready,
    output logic [C*W-1:0]             out_data,
    output logic [C*$clog2(D+1)-1:0]   occupancy
);

    localparam int CW = $clog2(D + 1);

    // One fully independent lane per channel.
    for (genvar c = 0; c < C; c++) begin : g_lane
        mxn_elastic_lane #(.W(W), .D(D), .CW(CW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush[c]),
            .in_valid  (in_valid[c]),
            .in_ready  (in_ready[c]),
            .in_data   (in_data[c*W +: W]),
            .out_valid (out_valid[c]),
            .out_ready (out_ready[c]),
            .out_data  (out_data[c*W +: W]),
            .occupancy (occupancy[c*CW +: CW])
        );
    end

endmodule

// File: tb/tb_mxn_elastic_pipeline.sv
// Directed bench for mxn_elastic_pipeline at W=3, D=4, C=2.
module tb_mxn_elastic_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] flush;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [5:0] in_data;
    logic [1:0] out_valid;
    logic [1:0] out_ready;
    logic [5:0] out_data;
    logic [5:0] occupancy;

    int n_pass  = 0;
    int n_total = 0;

    mxn_elastic_pipeline #(.W(3), .D(4), .C(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] od(input int c);
        return out_data[c*3 +: 3];
    endfunction

    function automatic logic [2:0] oc(input int c);
        return occupancy[c*3 +: 3];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 2'b00; in_valid = 2'b00; in_data = 6'd0; out_ready = 2'b00;
        tick();
        rst = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 2'b00) $display("FAIL reset_out_valid got=%b exp=00", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== 6'd0) $display("FAIL reset_out_data got=%h exp=0", out_data);
        else n_pass++;
        n_total++;
        if (occupancy !== 6'd0) $display("FAIL reset_occupancy got=%h exp=0", occupancy);
        else n_pass++;
        n_total++;
        if (in_ready !== 2'b11) $display("FAIL reset_in_ready got=%b exp=11", in_ready);
        else n_pass++;
    endtask

    task automatic test_stream();
        int exp_ov[10]  = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
        int exp_occ[10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
        out_ready = 2'b11;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid = {1'b0, (cyc < 5)};
            in_data  = {3'd0, 3'(cyc + 1)};
            #1;
            if (cyc < 5) begin
                n_total++;
                if (in_ready[0] !== 1'b1) $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", cyc, in_ready[0]);
                else n_pass++;
            end
            tick();
            n_total++;
            if (out_valid[0] !== 1'(exp_ov[cyc]))
                $display("FAIL stream_out_valid cyc=%0d got=%b exp=%0d", cyc, out_valid[0], exp_ov[cyc]);
            else n_pass++;
            if (exp_ov[cyc] == 1) begin
                n_total++;
                if (od(0) !== 3'(cyc - 2)) $display("FAIL stream_out_data cyc=%0d got=%0d exp=%0d", cyc, od(0), cyc - 2);
                else n_pass++;
            end
            n_total++;
            if (oc(0) !== 3'(exp_occ[cyc])) $display("FAIL stream_occupancy cyc=%0d got=%0d exp=%0d", cyc, oc(0), exp_occ[cyc]);
            else n_pass++;
        end
        in_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        out_ready = 2'b01;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = {1'b1, (cyc == 0)};
            in_data  = {((cyc < 4) ? 3'(cyc + 1) : 3'd5), 3'd7};
            #1;
            n_total++;
            if (in_ready[1] !== (cyc < 4)) $display("FAIL bp_in_ready cyc=%0d got=%b exp=%0d", cyc, in_ready[1], (cyc < 4));
            else n_pass++;
            tick();
            if (cyc == 3) begin
                n_total++;
                if (out_valid[0] !== 1'b1 || od(0) !== 3'd7)
                    $display("FAIL bp_lane0_indep got v=%b d=%0d exp v=1 d=7", out_valid[0], od(0));
                else n_pass++;
            end
        end
        n_total++;
        if (oc(1) !== 3'd4) $display("FAIL bp_full_occ got=%0d exp=4", oc(1));
        else n_pass++;
        n_total++;
        if (out_valid[1] !== 1'b1 || od(1) !== 3'd1) $display("FAIL bp_head got v=%b d=%0d exp v=1 d=1", out_valid[1], od(1));
        else n_pass++;
        n_total++;
        if (oc(0) !== 3'd0) $display("FAIL bp_lane0_occ got=%0d exp=0", oc(0));
        else n_pass++;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_total++;
            if (out_valid[1] !== 1'b1 || od(1) !== 3'(k))
                $display("FAIL bp_drain k=%0d got v=%b d=%0d exp v=1 d=%0d", k, out_valid[1], od(1), k);
            else n_pass++;
            tick();
        end
        n_total++;
        if (out_valid[1] !== 1'b0 || oc(1) !== 3'd0) $display("FAIL bp_empty got v=%b occ=%0d exp v=0 occ=0", out_valid[1], oc(1));
        else n_pass++;
    endtask

    task automatic test_bubble_collapse();
        out_ready = 2'b10;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = {1'b0, (cyc == 0 || cyc == 2)};
            in_data  = {3'd0, ((cyc == 0) ? 3'd7 : 3'd6)};
            tick();
            if (cyc >= 3) begin
                n_total++;
                if (out_valid[0] !== 1'b1 || od(0) !== 3'd7 || oc(0) !== 3'd2)
                    $display("FAIL bubble_stall cyc=%0d got v=%b d=%0d occ=%0d exp v=1 d=7 occ=2", cyc, out_valid[0], od(0), oc(0));
                else n_pass++;
            end
        end
        in_valid  = 2'b00;
        out_ready = 2'b11;
        #1;
        n_total++;
        if (out_valid[0] !== 1'b1 || od(0) !== 3'd7) $display("FAIL bubble_first got v=%b d=%0d exp v=1 d=7", out_valid[0], od(0));
        else n_pass++;
        tick();
        n_total++;
        if (out_valid[0] !== 1'b1 || od(0) !== 3'd6) $display("FAIL bubble_second got v=%b d=%0d exp v=1 d=6", out_valid[0], od(0));
        else n_pass++;
        tick();
        n_total++;
        if (out_valid[0] !== 1'b0 || oc(0) !== 3'd0) $display("FAIL bubble_empty got v=%b occ=%0d exp v=0 occ=0", out_valid[0], oc(0));
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 2'b10;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = {1'b0, (cyc < 3)};
            in_data  = {3'd0, 3'(cyc + 1)};
            tick();
        end
        n_total++;
        if (oc(0) !== 3'd3 || out_valid[0] !== 1'b1 || od(0) !== 3'd1)
            $display("FAIL flush_preload got occ=%0d v=%b d=%0d exp occ=3 v=1 d=1", oc(0), out_valid[0], od(0));
        else n_pass++;
        flush     = 2'b01;
        in_valid  = 2'b11;
        in_data   = {3'd5, 3'd4};
        out_ready = 2'b11;
        #1;
        n_total++;
        if (in_ready !== 2'b10) $display("FAIL flush_in_ready got=%b exp=10", in_ready);
        else n_pass++;
        n_total++;
        if (out_valid[0] !== 1'b1 || od(0) !== 3'd1) $display("FAIL flush_head_xfer got v=%b d=%0d exp v=1 d=1", out_valid[0], od(0));
        else n_pass++;
        tick();
        flush    = 2'b00;
        in_valid = 2'b00;
        n_total++;
        if (out_valid[0] !== 1'b0 || oc(0) !== 3'd0) $display("FAIL flush_empty got v=%b occ=%0d exp v=0 occ=0", out_valid[0], oc(0));
        else n_pass++;
        n_total++;
        if (oc(1) !== 3'd1) $display("FAIL flush_lane1_occ got=%0d exp=1", oc(1));
        else n_pass++;
        for (int j = 1; j <= 3; j++) begin
            tick();
            n_total++;
            if (out_valid[0] !== 1'b0) $display("FAIL flush_no_accept j=%0d got v=%b exp v=0", j, out_valid[0]);
            else n_pass++;
        end
        n_total++;
        if (out_valid[1] !== 1'b1 || od(1) !== 3'd5) $display("FAIL flush_lane1_out got v=%b d=%0d exp v=1 d=5", out_valid[1], od(1));
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 2'b00;
        for (int cyc = 0; cyc < 3; cyc++) begin
            in_valid = 2'b11;
            in_data  = {3'(cyc + 4), 3'(cyc + 1)};
            tick();
        end
        n_total++;
        if (occupancy !== {3'd3, 3'd3}) $display("FAIL rstmid_preload got occ1=%0d occ0=%0d exp 3/3", oc(1), oc(0));
        else n_pass++;
        rst     = 1'b1;
        in_data = {3'd7, 3'd7};
        tick();
        rst       = 1'b0;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        #1;
        n_total++;
        if (out_valid !== 2'b00 || out_data !== 6'd0 || occupancy !== 6'd0 || in_ready !== 2'b11)
            $display("FAIL rstmid_state got v=%b d=%h occ=%h rdy=%b exp v=00 d=0 occ=0 rdy=11", out_valid, out_data, occupancy, in_ready);
        else n_pass++;
        for (int j = 0; j < 6; j++) begin
            tick();
            n_total++;
            if (out_valid !== 2'b00) $display("FAIL rstmid_no_reappear j=%0d got v=%b exp v=00", j, out_valid);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
